// File: rtl/traj_trail_overlay.sv
// traj_trail_overlay: draws an outlined tracking box at the newest tracked point
// and a fading trail of square markers at the last DEPTH points, over the
// incoming VGA colour stream. Point updates are committed only at pixel (0,0),
// so a frame never shows a half-updated box or trail.
//
// Point strobe: i_pointVAL is a one-cycle qualifier with no back-pressure.
// Every strobe is accepted. A later strobe replaces an earlier one that has not
// been committed yet.
module traj_trail_overlay #(
    parameter int          DEPTH     = 8,
    parameter int          BOX_H     = 40,
    parameter int          BOX_V     = 40,
    parameter int          LINE_W    = 2,
    parameter int          MARK_W    = 1,
    parameter logic [29:0] BOX_COLOR = 30'h000C8000,
    parameter logic [9:0]  TRAIL_G   = 10'd800,
    parameter logic [9:0]  FADE_STEP = 10'd96
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [29:0]              i_color,
    input  logic [9:0]               i_h,
    input  logic [9:0]               i_v,
    input  logic                     i_rendering,
    input  logic [9:0]               i_pointH,
    input  logic [9:0]               i_pointV,
    input  logic                     i_pointVAL,
    input  logic [1:0]               i_mode,
    input  logic                     i_clear,
    output logic [29:0]              o_color,
    output logic                     o_rendering,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    localparam logic [10:0] LW11 = 11'(LINE_W);
    localparam logic [10:0] BH11 = 11'(BOX_H);
    localparam logic [10:0] BV11 = 11'(BOX_V);
    localparam logic [10:0] MW11 = 11'(MARK_W);

    // History ring and the pending (not yet committed) point
    logic [PW-1:0]    wr_ptr;
    logic             pend;
    logic [9:0]       pend_h;
    logic [9:0]       pend_v;
    logic [DEPTH-1:0] ent_val;
    logic [9:0]       ent_h [DEPTH];
    logic [9:0]       ent_v [DEPTH];

    logic             commit;
    logic             do_write;
    logic [9:0]       wr_h;
    logic [9:0]       wr_v;

    // Lower bound that stops at zero instead of wrapping
    function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : 11'd0;
    endfunction

    function automatic logic in_rng(input logic [10:0] x, input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    // Green level for a marker of the given age, floored at zero
    function automatic logic [9:0] fade_g(input int age);
        int g;
        g = int'(TRAIL_G) - age * int'(FADE_STEP);
        return (g < 0) ? 10'd0 : g[9:0];
    endfunction

    // A same-cycle strobe takes precedence over the pending point at commit
    assign commit   = (i_h == 10'd0) && (i_v == 10'd0);
    assign do_write = commit && !i_clear && (pend || i_pointVAL);
    assign wr_h     = i_pointVAL ? i_pointH : pend_h;
    assign wr_v     = i_pointVAL ? i_pointV : pend_v;

    // Point capture, commit into the ring, and clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            pend    <= 1'b0;
            pend_h  <= '0;
            pend_v  <= '0;
            ent_val <= '0;
            o_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_h[i] <= '0;
                ent_v[i] <= '0;
            end
        end else if (i_clear) begin
            wr_ptr  <= '0;
            pend    <= 1'b0;
            ent_val <= '0;
            o_count <= '0;
        end else if (do_write) begin
            ent_h[wr_ptr]   <= wr_h;
            ent_v[wr_ptr]   <= wr_v;
            ent_val[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PTR_ONE;
            pend            <= 1'b0;
            if (o_count != CNT_MAX) begin
                o_count <= o_count + CNT_ONE;
            end
        end else if (i_pointVAL) begin
            pend   <= 1'b1;
            pend_h <= i_pointH;
            pend_v <= i_pointV;
        end
    end

    // Box geometry around the newest entry, in 11-bit space so edges never wrap
    logic [PW-1:0] new_idx;
    logic [10:0]   h11, v11, bx_h, bx_v;
    logic          span_v, span_h, edge_l, edge_r, edge_t, edge_b, box_hit;

    assign new_idx = wr_ptr - PTR_ONE;
    assign h11     = {1'b0, i_h};
    assign v11     = {1'b0, i_v};
    assign bx_h    = {1'b0, ent_h[new_idx]};
    assign bx_v    = {1'b0, ent_v[new_idx]};

    assign span_v  = in_rng(v11, sat_sub(bx_v, LW11), bx_v + BV11 + LW11);
    assign span_h  = in_rng(h11, sat_sub(bx_h, LW11), bx_h + BH11 + LW11);
    assign edge_l  = span_v && in_rng(h11, sat_sub(bx_h, LW11), bx_h + LW11);
    assign edge_r  = span_v && in_rng(h11, sat_sub(bx_h + BH11, LW11), bx_h + BH11 + LW11);
    assign edge_t  = span_h && in_rng(v11, sat_sub(bx_v, LW11), bx_v + LW11);
    assign edge_b  = span_h && in_rng(v11, sat_sub(bx_v + BV11, LW11), bx_v + BV11 + LW11);
    assign box_hit = ent_val[new_idx] && (edge_l || edge_r || edge_t || edge_b);

    // Trail markers: scan oldest to newest so the youngest hit overwrites older ones
    logic          trail_hit;
    logic [9:0]    trail_g;
    logic [PW-1:0] t_idx;
    logic [10:0]   t_h, t_v;

    always_comb begin
        trail_hit = 1'b0;
        trail_g   = '0;
        t_idx     = '0;
        t_h       = '0;
        t_v       = '0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
            t_idx = wr_ptr - PTR_ONE - PW'(a);
            t_h   = {1'b0, ent_h[t_idx]};
            t_v   = {1'b0, ent_v[t_idx]};
            if (ent_val[t_idx] &&
                in_rng(h11, sat_sub(t_h, MW11), t_h + MW11) &&
                in_rng(v11, sat_sub(t_v, MW11), t_v + MW11)) begin
                trail_hit = 1'b1;
                trail_g   = fade_g(a);
            end
        end
    end

    // Overlay priority: blanking/passthrough, then box, then trail, then input
    logic [29:0] color_next;

    always_comb begin
        color_next = i_color;
        if (i_rendering && (i_mode != 2'd0)) begin
            if (i_mode[0] && box_hit) begin
                color_next = BOX_COLOR;
            end else if (i_mode[1] && trail_hit) begin
                color_next = {10'd0, trail_g, 10'd0};
            end
        end
    end

    // One-cycle output register for colour and the rendering flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_color     <= '0;
            o_rendering <= 1'b0;
        end else begin
            o_color     <= color_next;
            o_rendering <= i_rendering;
        end
    end

endmodule

// File: tb/tb_traj_trail_overlay.sv
// Bench for traj_trail_overlay: pixel tables per scenario plus hand-written
// strobe/commit/clear sequences. Expected colours go into exp_q when a pixel
// is driven and are popped when the registered output appears.
module tb_traj_trail_overlay;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [29:0] i_color;
    logic [9:0]  i_h;
    logic [9:0]  i_v;
    logic        i_rendering;
    logic [9:0]  i_pointH;
    logic [9:0]  i_pointV;
    logic        i_pointVAL;
    logic [1:0]  i_mode;
    logic        i_clear;
    logic [29:0] o_color;
    logic        o_rendering;
    logic [3:0]  o_count;

    localparam logic [29:0] BOXC = 30'h000C8000;

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q[$];

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [1:0]  mode;
        logic        rend;
        logic        pass;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];

    traj_trail_overlay dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_color     (i_color),
        .i_h         (i_h),
        .i_v         (i_v),
        .i_rendering (i_rendering),
        .i_pointH    (i_pointH),
        .i_pointV    (i_pointV),
        .i_pointVAL  (i_pointVAL),
        .i_mode      (i_mode),
        .i_clear     (i_clear),
        .o_color     (o_color),
        .o_rendering (o_rendering),
        .o_count     (o_count)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    function automatic logic [29:0] trail_c(input logic [9:0] g);
        return {10'd0, g, 10'd0};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input logic [3:0] exp);
        check(name, 32'(o_count), 32'(exp));
    endtask

    // Drive one pixel, queue its expected colour, compare one cycle later
    task automatic apply_pixel(input string name, input logic [9:0] h, input logic [9:0] v,
                               input logic [1:0] mode, input logic rend,
                               input logic [29:0] color, input logic [29:0] exp);
        logic [29:0] e;
        i_h         = h;
        i_v         = v;
        i_mode      = mode;
        i_rendering = rend;
        i_color     = color;
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        check(name, 32'(o_color), 32'(e));
        i_h = 10'd5;
        i_v = 10'd5;
    endtask

    task automatic add(input logic [9:0] h, input logic [9:0] v, input logic [1:0] mode,
                       input logic rend, input logic pass, input logic [29:0] exp);
        vec_t t;
        t.h = h; t.v = v; t.mode = mode; t.rend = rend; t.pass = pass; t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic run_vecs(input string tag);
        logic [29:0] c;
        for (int i = 0; i < vecs.size(); i++) begin
            c = {1'b1, 29'($urandom)};
            apply_pixel($sformatf("%s[%0d](%0d,%0d)", tag, i, vecs[i].h, vecs[i].v),
                        vecs[i].h, vecs[i].v, vecs[i].mode, vecs[i].rend, c,
                        vecs[i].pass ? c : vecs[i].exp);
        end
        vecs.delete();
    endtask

    task automatic strobe(input logic [9:0] ph, input logic [9:0] pv);
        i_h        = 10'd5;
        i_v        = 10'd5;
        i_pointVAL = 1'b1;
        i_pointH   = ph;
        i_pointV   = pv;
        tick();
        i_pointVAL = 1'b0;
    endtask

    task automatic do_clear();
        i_h     = 10'd5;
        i_v     = 10'd5;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    initial begin
        logic [29:0] c;
        i_rst_n     = 1'b0;
        i_color     = 30'h3FFFFFFF;
        i_h         = 10'd5;
        i_v         = 10'd5;
        i_rendering = 1'b1;
        i_pointH    = '0;
        i_pointV    = '0;
        i_pointVAL  = 1'b0;
        i_mode      = 2'd3;
        i_clear     = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_color", 32'(o_color), 32'h0);
        check("rst_rendering", 32'(o_rendering), 32'h0);
        check_count("rst_count", 4'd0);
        i_rst_n = 1'b1;

        // Empty history: everything passes through, including the commit pixel
        apply_pixel("empty_commit", 10'd0, 10'd0, 2'd3, 1'b1, 30'h3FFFFFFF, 30'h3FFFFFFF);
        add(10'd5, 10'd5, 2'd3, 1'b1, 1'b1, '0);
        add(10'd100, 10'd60, 2'd3, 1'b1, 1'b1, '0);
        add(10'd639, 10'd479, 2'd3, 1'b1, 1'b1, '0);
        add(10'd0, 10'd1, 2'd3, 1'b1, 1'b1, '0);
        run_vecs("empty");
        check_count("empty_count", 4'd0);
        i_rendering = 1'b0;
        tick();
        check("rend_delay0", 32'(o_rendering), 32'h0);
        i_rendering = 1'b1;
        tick();
        check("rend_delay1", 32'(o_rendering), 32'h1);

        // Single box at (100,50); the commit pixel still sees the empty history
        strobe(10'd100, 10'd50);
        check_count("pend_count", 4'd0);
        c = 30'h2ABCDEF1;
        apply_pixel("box1_commit", 10'd0, 10'd0, 2'd3, 1'b1, c, c);
        check_count("box1_count", 4'd1);
        add(10'd100, 10'd60, 2'd3, 1'b1, 1'b0, BOXC);
        add(10'd140, 10'd90, 2'd3, 1'b1, 1'b0, BOXC);
        add(10'd120, 10'd70, 2'd3, 1'b1, 1'b1, '0);
        add(10'd98, 10'd48, 2'd3, 1'b1, 1'b0, BOXC);
        add(10'd97, 10'd60, 2'd3, 1'b1, 1'b1, '0);
        add(10'd103, 10'd60, 2'd3, 1'b1, 1'b1, '0);
        add(10'd142, 10'd92, 2'd3, 1'b1, 1'b0, BOXC);
        add(10'd143, 10'd92, 2'd3, 1'b1, 1'b1, '0);
        add(10'd120, 10'd48, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd120, 10'd47, 2'd1, 1'b1, 1'b1, '0);
        add(10'd120, 10'd92, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd120, 10'd93, 2'd1, 1'b1, 1'b1, '0);
        add(10'd100, 10'd60, 2'd0, 1'b1, 1'b1, '0);
        add(10'd100, 10'd60, 2'd3, 1'b0, 1'b1, '0);
        add(10'd100, 10'd60, 2'd2, 1'b1, 1'b1, '0);
        add(10'd101, 10'd51, 2'd2, 1'b1, 1'b0, trail_c(10'd800));
        add(10'd102, 10'd50, 2'd2, 1'b1, 1'b1, '0);
        run_vecs("box1");

        // Box at (0,0): low edges clamp at zero, no wrap to the far side
        strobe(10'd0, 10'd0);
        c = 30'h21234567;
        apply_pixel("box0_commit", 10'd0, 10'd0, 2'd1, 1'b1, c, c);
        check_count("box0_count", 4'd2);
        add(10'd2, 10'd40, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd1, 10'd20, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd0, 10'd42, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd0, 10'd43, 2'd1, 1'b1, 1'b1, '0);
        add(10'd3, 10'd20, 2'd1, 1'b1, 1'b1, '0);
        add(10'd40, 10'd20, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd1022, 10'd20, 2'd1, 1'b1, 1'b1, '0);
        add(10'd20, 10'd1022, 2'd1, 1'b1, 1'b1, '0);
        add(10'd1023, 10'd1023, 2'd1, 1'b1, 1'b1, '0);
        run_vecs("box0");

        // Commit pixel draws the old box at (0,0) while the new point lands
        strobe(10'd300, 10'd300);
        apply_pixel("preupd_commit", 10'd0, 10'd0, 2'd1, 1'b1, 30'h3FFFFFFF, BOXC);
        check_count("preupd_count", 4'd3);
        add(10'd300, 10'd310, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd2, 10'd20, 2'd1, 1'b1, 1'b1, '0);
        run_vecs("preupd");

        // Clear, then ten points; the ring keeps the last eight
        do_clear();
        check_count("clear_count", 4'd0);
        add(10'd300, 10'd310, 2'd3, 1'b1, 1'b1, '0);
        run_vecs("cleared");
        for (int k = 1; k <= 10; k++) begin
            strobe(10'(10 * k), 10'd200);
            c = {1'b1, 29'($urandom)};
            apply_pixel($sformatf("trail_commit%0d", k), 10'd0, 10'd0, 2'd2, 1'b0, c, c);
        end
        check_count("trail_count", 4'd8);
        add(10'd100, 10'd200, 2'd2, 1'b1, 1'b0, trail_c(10'd800));
        add(10'd90, 10'd200, 2'd2, 1'b1, 1'b0, trail_c(10'd704));
        add(10'd80, 10'd200, 2'd2, 1'b1, 1'b0, trail_c(10'd608));
        add(10'd40, 10'd200, 2'd2, 1'b1, 1'b0, trail_c(10'd224));
        add(10'd30, 10'd200, 2'd2, 1'b1, 1'b0, trail_c(10'd128));
        add(10'd31, 10'd199, 2'd2, 1'b1, 1'b0, trail_c(10'd128));
        add(10'd20, 10'd200, 2'd2, 1'b1, 1'b1, '0);
        add(10'd10, 10'd200, 2'd2, 1'b1, 1'b1, '0);
        add(10'd95, 10'd200, 2'd2, 1'b1, 1'b1, '0);
        add(10'd101, 10'd201, 2'd2, 1'b1, 1'b0, trail_c(10'd800));
        add(10'd60, 10'd202, 2'd2, 1'b1, 1'b1, '0);
        add(10'd60, 10'd200, 2'd1, 1'b1, 1'b1, '0);
        run_vecs("trail");

        // Last strobe wins; a strobe on the commit pixel bypasses the pending point
        do_clear();
        strobe(10'd50, 10'd50);
        strobe(10'd300, 10'd300);
        c = 30'h2FEDCBA9;
        apply_pixel("last_commit", 10'd0, 10'd0, 2'd1, 1'b1, c, c);
        check_count("last_count", 4'd1);
        add(10'd300, 10'd310, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd340, 10'd340, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd50, 10'd60, 2'd1, 1'b1, 1'b1, '0);
        run_vecs("last");
        strobe(10'd200, 10'd100);
        i_pointVAL = 1'b1;
        i_pointH   = 10'd400;
        i_pointV   = 10'd100;
        apply_pixel("bypass_commit", 10'd0, 10'd0, 2'd1, 1'b1, c, c);
        i_pointVAL = 1'b0;
        check_count("bypass_count", 4'd2);
        add(10'd400, 10'd110, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd200, 10'd110, 2'd1, 1'b1, 1'b1, '0);
        run_vecs("bypass");

        // Clear on the commit pixel with a pending point and a strobe: clear wins
        strobe(10'd60, 10'd60);
        i_clear    = 1'b1;
        i_pointVAL = 1'b1;
        i_pointH   = 10'd10;
        i_pointV   = 10'd10;
        apply_pixel("clrcommit_pix", 10'd0, 10'd0, 2'd3, 1'b1, c, c);
        i_clear    = 1'b0;
        i_pointVAL = 1'b0;
        check_count("clrcommit_count", 4'd0);
        apply_pixel("clrcommit_next", 10'd0, 10'd0, 2'd3, 1'b1, c, c);
        check_count("clrcommit_count2", 4'd0);
        add(10'd400, 10'd110, 2'd3, 1'b1, 1'b1, '0);
        add(10'd10, 10'd10, 2'd3, 1'b1, 1'b1, '0);
        add(10'd11, 10'd11, 2'd3, 1'b1, 1'b1, '0);
        add(10'd60, 10'd60, 2'd3, 1'b1, 1'b1, '0);
        add(10'd300, 10'd310, 2'd3, 1'b1, 1'b1, '0);
        run_vecs("clrcommit");

        // History is still recorded in passthrough mode
        strobe(10'd500, 10'd400);
        apply_pixel("mode0_commit", 10'd0, 10'd0, 2'd0, 1'b1, c, c);
        check_count("mode0_count", 4'd1);
        add(10'd500, 10'd410, 2'd0, 1'b1, 1'b1, '0);
        add(10'd500, 10'd410, 2'd1, 1'b1, 1'b0, BOXC);
        add(10'd540, 10'd440, 2'd3, 1'b1, 1'b0, BOXC);
        add(10'd520, 10'd420, 2'd3, 1'b1, 1'b1, '0);
        run_vecs("mode0");

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
